// File: rtl/video_pkg.sv
// Shared constants and types for the grayscale downsampling video path.
// The luma weights sum to 256, so the rounded result never exceeds 255.
package video_pkg;

    localparam logic [7:0]  COEF_R  = 8'd77;
    localparam logic [7:0]  COEF_G  = 8'd150;
    localparam logic [7:0]  COEF_B  = 8'd29;
    localparam logic [15:0] ROUND_C = 16'd128;
    localparam int          ENTRY_W = 10;

    typedef struct packed {
        logic       sof;
        logic       eol;
        logic [7:0] gray;
    } entry_t;

    function automatic logic [15:0] mul_coef(input logic [7:0] a, input logic [7:0] c);
        return 16'(a) * 16'(c);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO with extra-MSB pointers.
// A push into a full FIFO is still taken when a pop happens in the same cycle.
module sync_fifo #(
    parameter int DW = 10,
    parameter int AW = 4
) (
    input  logic          i_clk,
    input  logic          i_rstn,
    input  logic          i_push,
    input  logic [DW-1:0] i_din,
    input  logic          i_pop,
    output logic [DW-1:0] o_dout,
    output logic          o_valid,
    output logic          o_drop
);

    logic [DW-1:0] r_mem [0:(1<<AW)-1];
    logic [AW:0]   r_wr_ptr;
    logic [AW:0]   r_rd_ptr;
    logic          w_empty;
    logic          w_full;
    logic          w_pop;
    logic          w_wr;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop   = i_pop && !w_empty;
    assign w_wr    = i_push && (!w_full || w_pop);
    assign o_drop  = i_push && w_full && !w_pop;
    assign o_valid = !w_empty;
    assign o_dout  = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr)  r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage is deliberately left unreset; the head is only meaningful while o_valid=1.
    always_ff @(posedge i_clk) begin
        if (w_wr) r_mem[r_wr_ptr[AW-1:0]] <= i_din;
    end

endmodule

// File: rtl/video_gray_ds.sv
// RGB-to-luma conversion with 2:1 decimation in both directions, buffered in a FIFO.
// Pixels are only kept once a frame start (vs_i rising edge) has been seen after reset.
module video_gray_ds
    import video_pkg::*;
#(
    parameter int IMG_W   = 640,
    parameter int IMG_H   = 480,
    parameter int FIFO_AW = 4
) (
    input  logic        cmos_pclk_i,
    input  logic        rstn_i,
    input  logic [23:0] rgb_i,
    input  logic        de_i,
    input  logic        vs_i,
    input  logic        hs_i,
    output logic [7:0]  gray_o,
    output logic        sof_o,
    output logic        eol_o,
    output logic        valid_o,
    input  logic        ready_i,
    output logic        ovf_o
);

    localparam logic [10:0] W_LIM = 11'(IMG_W);
    localparam logic [10:0] H_LIM = 11'(IMG_H);
    localparam logic [10:0] EOL_X = 11'(IMG_W - 2);

    logic        r_vs_d;
    logic        r_hs_d;
    logic        r_armed;
    logic [10:0] r_x_cnt;
    logic [10:0] r_y_cnt;
    logic        w_vs_rise;
    logic        w_hs_fall;
    logic        w_keep;
    logic        w_sof;
    logic        w_eol;

    logic        r_s1_vld;
    logic        r_s1_sof;
    logic        r_s1_eol;
    logic [15:0] r_prod_r;
    logic [15:0] r_prod_g;
    logic [15:0] r_prod_b;
    logic [7:0]  w_gray;

    logic        r_s2_vld;
    entry_t      r_s2_entry;
    entry_t      w_head;
    logic        w_drop;

    assign w_vs_rise = vs_i && !r_vs_d;
    assign w_hs_fall = !hs_i && r_hs_d;

    assign w_keep = de_i && r_armed && !r_x_cnt[0] && !r_y_cnt[0] &&
                    (r_x_cnt < W_LIM) && (r_y_cnt < H_LIM);
    assign w_sof  = w_keep && (r_x_cnt == 11'd0) && (r_y_cnt == 11'd0);
    assign w_eol  = w_keep && (r_x_cnt == EOL_X);

    always_ff @(posedge cmos_pclk_i) begin
        if (!rstn_i) begin
            r_vs_d  <= 1'b0;
            r_hs_d  <= 1'b0;
            r_armed <= 1'b0;
            r_x_cnt <= '0;
            r_y_cnt <= '0;
        end else begin
            r_vs_d <= vs_i;
            r_hs_d <= hs_i;
            if (w_vs_rise) r_armed <= 1'b1;

            if (w_vs_rise || w_hs_fall) r_x_cnt <= '0;
            else if (de_i)              r_x_cnt <= r_x_cnt + 11'd1;

            // Empty hs windows must not advance the row, or the row parity breaks.
            if (w_vs_rise)                          r_y_cnt <= '0;
            else if (w_hs_fall && r_x_cnt != 11'd0) r_y_cnt <= r_y_cnt + 11'd1;
        end
    end

    always_ff @(posedge cmos_pclk_i) begin
        if (!rstn_i) begin
            r_s1_vld <= 1'b0;
            r_s1_sof <= 1'b0;
            r_s1_eol <= 1'b0;
            r_s2_vld <= 1'b0;
        end else begin
            r_s1_vld <= w_keep;
            r_s1_sof <= w_sof;
            r_s1_eol <= w_eol;
            r_s2_vld <= r_s1_vld;
        end
    end

    assign w_gray = 8'((r_prod_r + r_prod_g + r_prod_b + ROUND_C) >> 8);

    always_ff @(posedge cmos_pclk_i) begin
        r_prod_r        <= mul_coef(rgb_i[23:16], COEF_R);
        r_prod_g        <= mul_coef(rgb_i[15:8],  COEF_G);
        r_prod_b        <= mul_coef(rgb_i[7:0],   COEF_B);
        r_s2_entry.sof  <= r_s1_sof;
        r_s2_entry.eol  <= r_s1_eol;
        r_s2_entry.gray <= w_gray;
    end

    sync_fifo #(
        .DW (ENTRY_W),
        .AW (FIFO_AW)
    ) u_fifo (
        .i_clk   (cmos_pclk_i),
        .i_rstn  (rstn_i),
        .i_push  (r_s2_vld),
        .i_din   (r_s2_entry),
        .i_pop   (ready_i),
        .o_dout  (w_head),
        .o_valid (valid_o),
        .o_drop  (w_drop)
    );

    assign gray_o = w_head.gray;
    assign sof_o  = w_head.sof;
    assign eol_o  = w_head.eol;

    // A drop in the frame-start cycle belongs to the new frame, so set beats clear.
    always_ff @(posedge cmos_pclk_i) begin
        if (!rstn_i)        ovf_o <= 1'b0;
        else if (w_drop)    ovf_o <= 1'b1;
        else if (w_vs_rise) ovf_o <= 1'b0;
    end

endmodule

// File: tb/tb_video_gray_ds.sv
// Bench for video_gray_ds: a 4x4 instance for tagging/decimation and a 640x480 instance for FIFO depth.
// Expected entries come from frame/line/pixel indices and the luma formula in plain integer arithmetic.
module tb_video_gray_ds;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [23:0] rgb   [2];
    logic        de    [2];
    logic        vs    [2];
    logic        hs    [2];
    logic        ready [2];
    logic [7:0]  gray  [2];
    logic        sof   [2];
    logic        eol   [2];
    logic        valid [2];
    logic        ovf   [2];

    int          n_tests = 0;
    int          n_fail  = 0;
    bit          armed   [2];
    bit          rand_rdy = 1'b0;
    bit          use_fixed = 1'b0;
    logic [23:0] fixed_col [4];
    int          W_ARR [2] = '{4, 640};
    int          H_ARR [2] = '{4, 480};
    logic [9:0]  exp0[$], exp1[$], got0[$], got1[$];

    always #5 clk = ~clk;

    video_gray_ds #(.IMG_W(4), .IMG_H(4), .FIFO_AW(4)) u_small (
        .cmos_pclk_i (clk),      .rstn_i  (rstn),
        .rgb_i       (rgb[0]),   .de_i    (de[0]),
        .vs_i        (vs[0]),    .hs_i    (hs[0]),
        .gray_o      (gray[0]),  .sof_o   (sof[0]),
        .eol_o       (eol[0]),   .valid_o (valid[0]),
        .ready_i     (ready[0]), .ovf_o   (ovf[0])
    );

    video_gray_ds #(.IMG_W(640), .IMG_H(480), .FIFO_AW(4)) u_big (
        .cmos_pclk_i (clk),      .rstn_i  (rstn),
        .rgb_i       (rgb[1]),   .de_i    (de[1]),
        .vs_i        (vs[1]),    .hs_i    (hs[1]),
        .gray_o      (gray[1]),  .sof_o   (sof[1]),
        .eol_o       (eol[1]),   .valid_o (valid[1]),
        .ready_i     (ready[1]), .ovf_o   (ovf[1])
    );

    // Record every entry the consumer actually takes (a pop happens at the next rising edge).
    always @(negedge clk) begin
        if (rstn && valid[0] && ready[0]) got0.push_back({sof[0], eol[0], gray[0]});
        if (rstn && valid[1] && ready[1]) got1.push_back({sof[1], eol[1], gray[1]});
    end

    function automatic logic [7:0] luma(input logic [23:0] c);
        int y;
        y = (77 * int'(c[23:16]) + 150 * int'(c[15:8]) + 29 * int'(c[7:0]) + 128) / 256;
        return y[7:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_rdy) ready[0] = 1'($urandom_range(0, 1));
    endtask

    task automatic clear_q();
        exp0.delete(); exp1.delete(); got0.delete(); got1.delete();
    endtask

    task automatic vs_pulse(input int d);
        vs[d] = 1'b1;
        repeat (3) tick();
        vs[d] = 1'b0;
        tick();
        armed[d] = 1'b1;
    endtask

    task automatic empty_hs(input int d);
        hs[d] = 1'b1;
        repeat (3) tick();
        hs[d] = 1'b0;
        repeat (2) tick();
    endtask

    // l is the index of this non-empty line within the frame.
    task automatic drive_line(input int d, input int l, input int npix, input int gmax);
        logic [23:0] c;
        logic [9:0]  e;
        bit          kept;
        hs[d] = 1'b1;
        tick();
        for (int p = 0; p < npix; p++) begin
            kept = armed[d] && (p % 2 == 0) && (l % 2 == 0) && (p < W_ARR[d]) && (l < H_ARR[d]);
            c = $urandom;
            if (use_fixed && kept) c = fixed_col[(l / 2) * 2 + p / 2];
            if (kept) begin
                e = {(p == 0 && l == 0), (p == W_ARR[d] - 2), luma(c)};
                if (d == 0) exp0.push_back(e); else exp1.push_back(e);
            end
            rgb[d] = c;
            de[d]  = 1'b1;
            tick();
            de[d]  = 1'b0;
            repeat ($urandom_range(0, gmax)) tick();
        end
        tick();
        hs[d] = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_reset();
        for (int d = 0; d < 2; d++) begin
            rgb[d] = '0; de[d] = 1'b0; vs[d] = 1'b0; hs[d] = 1'b0; ready[d] = 1'b1;
            armed[d] = 1'b0;
        end
        rstn = 1'b0;
        repeat (3) tick();
        for (int d = 0; d < 2; d++) begin
            n_tests++;
            if (valid[d] !== 1'b0) begin
                n_fail++; $display("FAIL reset_valid dut%0d got %b want 0", d, valid[d]);
            end
            n_tests++;
            if (ovf[d] !== 1'b0) begin
                n_fail++; $display("FAIL reset_ovf dut%0d got %b want 0", d, ovf[d]);
            end
        end
        rstn = 1'b1;
        tick();
        clear_q();
        drive_line(0, 0, 4, 1);
        repeat (10) tick();
        n_tests++;
        if (got0.size() != 0) begin
            n_fail++; $display("FAIL unarmed_out got %0d entries want 0", got0.size());
        end
    endtask

    task automatic test_frame_4x4();
        logic [1:0] tags [4] = '{2'b10, 2'b01, 2'b00, 2'b01};
        clear_q();
        vs_pulse(0);
        for (int l = 0; l < 4; l++) drive_line(0, l, 4, 2);
        repeat (10) tick();
        n_tests++;
        if (got0.size() != 4) begin
            n_fail++; $display("FAIL frame4x4_count got %0d want 4", got0.size());
        end
        for (int i = 0; i < got0.size() && i < 4; i++) begin
            n_tests++;
            if (got0[i] !== exp0[i] || got0[i][9:8] !== tags[i]) begin
                n_fail++;
                $display("FAIL frame4x4_entry%0d got %h want %h tags %b", i, got0[i], exp0[i], tags[i]);
            end
        end
    endtask

    task automatic test_colors();
        logic [7:0] want [4] = '{8'd77, 8'd149, 8'd29, 8'd255};
        fixed_col[0] = 24'hFF0000; fixed_col[1] = 24'h00FF00;
        fixed_col[2] = 24'h0000FF; fixed_col[3] = 24'hFFFFFF;
        use_fixed = 1'b1;
        clear_q();
        vs_pulse(0);
        for (int l = 0; l < 4; l++) drive_line(0, l, 4, 0);
        repeat (10) tick();
        use_fixed = 1'b0;
        n_tests++;
        if (got0.size() != 4) begin
            n_fail++; $display("FAIL colors_count got %0d want 4", got0.size());
        end
        for (int i = 0; i < got0.size() && i < 4; i++) begin
            n_tests++;
            if (got0[i][7:0] !== want[i]) begin
                n_fail++; $display("FAIL colors_gray%0d got %0d want %0d", i, got0[i][7:0], want[i]);
            end
        end
    endtask

    task automatic test_empty_hs();
        clear_q();
        vs_pulse(0);
        empty_hs(0);
        drive_line(0, 0, 4, 1);
        empty_hs(0);
        drive_line(0, 1, 4, 1);
        drive_line(0, 2, 4, 1);
        empty_hs(0);
        drive_line(0, 3, 4, 1);
        repeat (10) tick();
        n_tests++;
        if (got0.size() != exp0.size()) begin
            n_fail++; $display("FAIL empty_hs_count got %0d want %0d", got0.size(), exp0.size());
        end
        for (int i = 0; i < got0.size() && i < exp0.size(); i++) begin
            n_tests++;
            if (got0[i] !== exp0[i]) begin
                n_fail++; $display("FAIL empty_hs_entry%0d got %h want %h", i, got0[i], exp0[i]);
            end
        end
    endtask

    task automatic test_bounds();
        clear_q();
        vs_pulse(0);
        for (int l = 0; l < 6; l++) drive_line(0, l, 6, 1);
        repeat (10) tick();
        n_tests++;
        if (got0.size() != 4 || exp0.size() != 4) begin
            n_fail++; $display("FAIL bounds_count got %0d want 4", got0.size());
        end
        for (int i = 0; i < got0.size() && i < exp0.size(); i++) begin
            n_tests++;
            if (got0[i] !== exp0[i]) begin
                n_fail++; $display("FAIL bounds_entry%0d got %h want %h", i, got0[i], exp0[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        clear_q();
        rand_rdy = 1'b1;
        for (int f = 0; f < 3; f++) begin
            vs_pulse(0);
            for (int l = 0; l < 4; l++) drive_line(0, l, 4, $urandom_range(0, 2));
        end
        rand_rdy = 1'b0;
        ready[0] = 1'b1;
        repeat (30) tick();
        n_tests++;
        if (ovf[0] !== 1'b0) begin
            n_fail++; $display("FAIL b2b_ovf got %b want 0", ovf[0]);
        end
        n_tests++;
        if (got0.size() != exp0.size()) begin
            n_fail++; $display("FAIL b2b_count got %0d want %0d", got0.size(), exp0.size());
        end
        for (int i = 0; i < got0.size() && i < exp0.size(); i++) begin
            n_tests++;
            if (got0[i] !== exp0[i]) begin
                n_fail++; $display("FAIL b2b_entry%0d got %h want %h", i, got0[i], exp0[i]);
            end
        end
    endtask

    task automatic test_overflow();
        logic [23:0] c;
        clear_q();
        ready[1] = 1'b0;
        vs_pulse(1);
        hs[1] = 1'b1;
        tick();
        for (int p = 0; p < 640; p++) begin
            c = $urandom;
            if (p % 2 == 0 && p < 32) exp1.push_back({(p == 0), (p == 638), luma(c)});
            rgb[1] = c;
            de[1]  = 1'b1;
            tick();
            de[1]  = 1'b0;
            if (p == 30) begin
                repeat (4) tick();
                n_tests++;
                if (ovf[1] !== 1'b0 || valid[1] !== 1'b1) begin
                    n_fail++; $display("FAIL ovf_at16 got ovf=%b valid=%b want ovf=0 valid=1", ovf[1], valid[1]);
                end
            end
            if (p == 32) begin
                repeat (4) tick();
                n_tests++;
                if (ovf[1] !== 1'b1) begin
                    n_fail++; $display("FAIL ovf_at17 got %b want 1", ovf[1]);
                end
            end
        end
        tick();
        hs[1] = 1'b0;
        repeat (2) tick();
        drive_line(1, 1, 40, 0);
        drive_line(1, 2, 40, 0);
        exp1 = exp1[0:15];
        n_tests++;
        if (ovf[1] !== 1'b1) begin
            n_fail++; $display("FAIL ovf_sticky got %b want 1", ovf[1]);
        end
        vs_pulse(1);
        n_tests++;
        if (ovf[1] !== 1'b0) begin
            n_fail++; $display("FAIL ovf_clear got %b want 0", ovf[1]);
        end

        // Full FIFO: a push and a pop land on the same edge.
        hs[1] = 1'b1;
        tick();
        c = $urandom;
        exp1.push_back({1'b1, 1'b0, luma(c)});
        rgb[1] = c;
        de[1]  = 1'b1;
        tick();
        de[1]  = 1'b0;
        tick();
        ready[1] = 1'b1;
        tick();
        ready[1] = 1'b0;
        repeat (3) tick();
        n_tests++;
        if (ovf[1] !== 1'b0) begin
            n_fail++; $display("FAIL push_pop_full_ovf got %b want 0", ovf[1]);
        end
        hs[1] = 1'b0;
        repeat (2) tick();
        ready[1] = 1'b1;
        repeat (40) tick();
        n_tests++;
        if (got1.size() != 17) begin
            n_fail++; $display("FAIL full_drain_count got %0d want 17", got1.size());
        end
        for (int i = 0; i < got1.size() && i < exp1.size(); i++) begin
            n_tests++;
            if (got1[i] !== exp1[i]) begin
                n_fail++; $display("FAIL full_drain_entry%0d got %h want %h", i, got1[i], exp1[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        clear_q();
        ready[1] = 1'b0;
        vs_pulse(1);
        hs[1] = 1'b1;
        tick();
        for (int p = 0; p < 10; p++) begin
            rgb[1] = $urandom;
            de[1]  = 1'b1;
            tick();
            de[1]  = 1'b0;
        end
        repeat (4) tick();
        n_tests++;
        if (valid[1] !== 1'b1) begin
            n_fail++; $display("FAIL pre_reset_valid got %b want 1", valid[1]);
        end
        rstn  = 1'b0;
        hs[1] = 1'b0;
        tick();
        n_tests++;
        if (valid[1] !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset_valid got %b want 0", valid[1]);
        end
        rstn = 1'b1;
        armed[0] = 1'b0;
        armed[1] = 1'b0;
        ready[1] = 1'b1;
        clear_q();
        drive_line(1, 0, 20, 0);
        drive_line(1, 1, 4, 0);
        drive_line(1, 2, 20, 0);
        repeat (10) tick();
        n_tests++;
        if (got1.size() != 0 || valid[1] !== 1'b0) begin
            n_fail++; $display("FAIL post_reset_ignored got %0d entries valid=%b want 0", got1.size(), valid[1]);
        end
        vs_pulse(1);
        drive_line(1, 0, 640, 0);
        drive_line(1, 1, 8, 0);
        drive_line(1, 2, 8, 1);
        repeat (10) tick();
        n_tests++;
        if (got1.size() != exp1.size() || got1.size() == 0) begin
            n_fail++; $display("FAIL rearm_count got %0d want %0d", got1.size(), exp1.size());
        end else begin
            n_tests++;
            if (got1[0][9] !== 1'b1) begin
                n_fail++; $display("FAIL rearm_sof got %b want 1", got1[0][9]);
            end
        end
        for (int i = 0; i < got1.size() && i < exp1.size(); i++) begin
            n_tests++;
            if (got1[i] !== exp1[i]) begin
                n_fail++; $display("FAIL rearm_entry%0d got %h want %h", i, got1[i], exp1[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_frame_4x4();
        test_colors();
        test_empty_hs();
        test_bounds();
        test_back_to_back();
        test_overflow();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/video_gray_ds.md
VIDEO_GRAY_DS -- requirements
Module: video_gray_ds

Interface
REQ-001 Parameter IMG_W, default 640, meaning active pixels per line at the input.
REQ-002 Parameter IMG_H, default 480, meaning active lines per frame at the input.
REQ-003 Parameter FIFO_AW, default 4, meaning output FIFO address width (depth 2**FIFO_AW).
REQ-004 Port cmos_pclk_i  input  1  meaning the single clock, the camera pixel clock; all logic is on its rising edge.
REQ-005 Port rstn_i  input  1  meaning reset, synchronous and active-low.
REQ-006 Port rgb_i  input  24  meaning pixel {R[23:16],G[15:8],B[7:0]}, valid when de_i=1.
REQ-007 Port de_i  input  1  meaning one-cycle pixel strobe, one pulse per pixel.
REQ-008 Port vs_i  input  1  meaning vertical sync, high during frame blanking.
REQ-009 Port hs_i  input  1  meaning line-active window, high across each line.
REQ-010 Port gray_o  output  8  meaning luma of the FIFO head entry.
REQ-011 Port sof_o  output  1  meaning the head entry is pixel (0,0) of the output frame.
REQ-012 Port eol_o  output  1  meaning the head entry is the last pixel of an output line.
REQ-013 Port valid_o  output  1  meaning the FIFO is non-empty.
REQ-014 Port ready_i  input  1  meaning the consumer accepts the head entry; a pop occurs when valid_o&&ready_i.
REQ-015 Port ovf_o  output  1  meaning sticky flag: a pixel was dropped in the current frame.

Function
REQ-016 Frame start SHALL be the rising edge of vs_i, detected against a registered copy; it clears x_cnt, y_cnt and ovf_o.
REQ-017 x_cnt (11 bit) SHALL increment on each de_i pulse and clear on the falling edge of hs_i.
REQ-018 y_cnt (11 bit) SHALL increment on the falling edge of hs_i only if x_cnt!=0, so empty hs windows are ignored.
REQ-019 A pixel is kept iff x_cnt[0]==0, y_cnt[0]==0, x_cnt<IMG_W and y_cnt<IMG_H; output frame size is IMG_W/2 x IMG_H/2.
REQ-020 Luma SHALL be Y=(77*R+150*G+29*B+128)>>8 computed in 16-bit unsigned; no saturation is needed (max 255).
REQ-021 Conversion SHALL be a 2-stage pipeline: stage 1 registers the three products and the keep/sof/eol tags; stage 2 registers the sum; the FIFO write occurs 2 cycles after the de_i pulse.
REQ-022 sof tag = kept with x_cnt==0 and y_cnt==0; eol tag = kept with x_cnt==IMG_W-2.
REQ-023 The FIFO entry is {sof,eol,gray}, 10 bits wide; show-ahead: gray_o/sof_o/eol_o reflect the head combinationally from storage.
REQ-024 A push when full SHALL be dropped and set ovf_o, unless a pop occurs in the same cycle, in which case the push is accepted.
REQ-025 A simultaneous push and pop when empty SHALL leave the FIFO with one entry; valid_o asserts the next cycle.
REQ-026 Pointers SHALL be FIFO_AW+1 bits wide; full = MSBs differ and LSBs equal; empty = pointers equal.
REQ-027 A vs_i rising edge SHALL NOT flush the FIFO; in-flight pipeline entries still write.
REQ-028 ovf_o SHALL clear on a vs_i rising edge; if a drop occurs in the same cycle, the set wins.

Reset
REQ-029 With rstn_i=0 at a clock edge: x_cnt, y_cnt, pipeline valids, both FIFO pointers, ovf_o and the vs/hs edge registers clear; valid_o=0 the next cycle.
REQ-030 Reset mid-frame SHALL discard all FIFO contents; after release, no pixel is kept until the next vs_i rising edge (frame_armed flag, reset 0).
REQ-031 FIFO storage RAM is not reset; gray_o/sof_o/eol_o are don't-care while valid_o=0.

Structure
REQ-032 The luma coefficients (77, 150, 29), the rounding constant 128 and the entry width 10 SHALL live in shared package video_pkg.
REQ-033 The FIFO SHALL be sub-module sync_fifo (parameters DW, AW), reusable elsewhere in the design.

Verification
REQ-034 Reset, then a vs_i pulse, then a 4x4 frame with IMG_W=4, IMG_H=4 and ready_i=1 -> 4 outputs at (0,0),(2,0),(0,2),(2,2); sof on the first output, eol on the 2nd and 4th.
REQ-035 Pixels FF0000, 00FF00, 0000FF, FFFFFF -> gray 77, 149, 29, 255 (each kept).
REQ-036 ready_i=0 for a full 640x480 frame with FIFO_AW=4 -> exactly 16 entries held, ovf_o=1 after the 17th kept pixel; the next vs_i rising edge clears ovf_o.
REQ-037 FIFO full with push and pop in the same cycle -> entry accepted, count stays 16, ovf_o stays 0.
REQ-038 rstn_i=0 mid-line with 5 entries queued -> valid_o=0; after release, pixels are ignored until vs_i rises; the next frame outputs from sof.
REQ-039 An hs_i pulse with no de_i between frames -> y_cnt unchanged; output row parity remains correct.
